// File: rtl/ser4_tx_pkg.sv
// Shared definitions for the ser4_tx serialiser: FSM state encoding, the
// default per-lane training word and a counter-width helper.
package ser4_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [3:0] DEF_TRAIN_PAT = 4'b0001;

    // Keeps counters at least one bit wide when the count range is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ser4_tx_if.sv
// Word-input handshake of the ser4_tx serialiser: one RATIO-bit word per lane
// is transferred on a cycle where s_valid and s_ready are both high.
interface ser4_tx_if #(
    parameter int LANES = 2,
    parameter int RATIO = 4
) ();

    logic                   s_valid;
    logic                   s_ready;
    logic [LANES*RATIO-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/ser4_lane.sv
// One serial lane: RATIO-bit shift register that emits bit 0 and shifts
// right with zero fill whenever it is not being loaded.
module ser4_lane #(
    parameter int RATIO = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [RATIO-1:0] din,
    output logic             dout
);

    logic [RATIO-1:0] sr;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else begin
            sr <= sr >> 1;
        end
    end

    assign dout = sr[0];

endmodule

// File: rtl/ser4_tx.sv
// 4:1 parallel-to-serial transmitter feeding the IDES4 receive links; also
// generates the training sequence the receiver bitslips against.
module ser4_tx
    import ser4_tx_pkg::*;
#(
    parameter int               LANES       = 2,
    parameter int               RATIO       = 4,
    parameter logic [RATIO-1:0] TRAIN_PAT   = DEF_TRAIN_PAT,
    parameter int               TRAIN_WORDS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             train_i,
    ser4_tx_if.slave         s,
    output logic [LANES-1:0] d_o,
    output logic             frame_o,
    output logic             busy_o
);

    localparam int BW = cnt_width(RATIO);
    localparam int WW = cnt_width(TRAIN_WORDS);

    state_t                 state, state_nx;
    logic [BW-1:0]          bcnt, bcnt_nx;
    logic [WW-1:0]          wcnt, wcnt_nx;
    logic                   pending, pending_nx;
    logic                   frame_nx;
    logic                   last_bit, boundary, decide;
    logic                   load;
    logic [LANES*RATIO-1:0] load_word;

    assign last_bit = (bcnt == BW'(RATIO - 1));
    assign boundary = (state == IDLE) || last_bit;
    // Inside a training sequence only the final word's end re-runs arbitration.
    assign decide   = (state == IDLE) ||
                      (last_bit && ((state == SEND) || (wcnt == WW'(TRAIN_WORDS - 1))));

    assign s.s_ready = boundary && !pending && !train_i && (state != TRAIN);

    always_comb begin
        state_nx   = state;
        bcnt_nx    = (state == IDLE) ? '0 : bcnt + 1'b1;
        wcnt_nx    = wcnt;
        pending_nx = pending | train_i;
        load       = 1'b0;
        load_word  = '0;
        if (decide) begin
            pending_nx = 1'b0;
            load       = 1'b1;
            bcnt_nx    = '0;
            if (pending || train_i) begin
                state_nx  = TRAIN;
                wcnt_nx   = '0;
                load_word = {LANES{TRAIN_PAT}};
            end else if (s.s_valid && s.s_ready) begin
                state_nx  = SEND;
                load_word = s.s_data;
            end else begin
                state_nx  = IDLE;
            end
        end else if ((state == TRAIN) && last_bit) begin
            load      = 1'b1;
            bcnt_nx   = '0;
            wcnt_nx   = wcnt + 1'b1;
            load_word = {LANES{TRAIN_PAT}};
        end
        frame_nx = load && (state_nx != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            bcnt    <= '0;
            wcnt    <= '0;
            pending <= 1'b0;
            frame_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_nx;
            bcnt    <= bcnt_nx;
            wcnt    <= wcnt_nx;
            pending <= pending_nx;
            frame_o <= frame_nx;
            busy_o  <= (state_nx != IDLE);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ser4_lane #(.RATIO(RATIO)) u_lane (
            .clock (clock),
            .reset (reset),
            .load  (load),
            .din   (load_word[l*RATIO +: RATIO]),
            .dout  (d_o[l])
        );
    end

endmodule

// File: tb/tb_ser4_tx.sv
// Self-checking bench for ser4_tx: a bit-schedule reference model predicts every
// cycle, and a frame-aligned deserialiser checks the words seen on the line.
module tb_ser4_tx;

    localparam int         TW         = 8;
    localparam logic [7:0] TRAIN_WORD = 8'h11;

    typedef struct {
        logic [1:0] d;
        logic       frame;
        logic       train;
    } slot_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       train_i = 1'b0;
    logic [1:0] d_o;
    logic       frame_o;
    logic       busy_o;

    ser4_tx_if #(.LANES(2), .RATIO(4)) bus ();

    ser4_tx #(
        .LANES       (2),
        .RATIO       (4),
        .TRAIN_PAT   (4'b0001),
        .TRAIN_WORDS (TW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .train_i (train_i),
        .s       (bus.slave),
        .d_o     (d_o),
        .frame_o (frame_o),
        .busy_o  (busy_o)
    );

    always #5 clock = ~clock;

    // Model: queue of bit slots still to appear on the line, slot 0 = current cycle.
    slot_t      sched[$];
    bit         m_pend;
    logic [7:0] exp_words[$];
    logic [7:0] rx_words[$];
    logic [7:0] rx_cur;
    int         rx_idx = 4;
    int         checks = 0;
    int         failures = 0;
    logic       exp_ready, obs_ready;
    logic [4:0] exp_vec, obs_vec;

    task automatic push_word(input logic [7:0] w, input bit tr);
        for (int k = 0; k < 4; k++) begin
            slot_t sl;
            sl.d     = {w[4+k], w[k]};
            sl.frame = (k == 0);
            sl.train = tr;
            sched.push_back(sl);
        end
        exp_words.push_back(w);
    endtask

    task automatic drive_cycle(input bit rst, input bit v, input logic [7:0] data, input bit tr);
        bit decide;
        reset         = rst;
        bus.s_valid   = v;
        bus.s_data    = data;
        train_i       = tr;
        decide        = (sched.size() <= 1);
        exp_ready     = (sched.size() == 0 || (sched.size() == 1 && !sched[0].train)) && !m_pend && !tr;
        #1;
        obs_ready     = bus.s_ready;
        @(posedge clock);
        if (rst) begin
            sched.delete();
            exp_words.delete();
            rx_words.delete();
            m_pend = 1'b0;
            rx_idx = 4;
        end else begin
            if (sched.size() > 0) void'(sched.pop_front());
            if (decide) begin
                if (m_pend || tr) begin
                    for (int i = 0; i < TW; i++) push_word(TRAIN_WORD, 1'b1);
                    m_pend = 1'b0;
                end else if (v && exp_ready) begin
                    push_word(data, 1'b0);
                end
            end else begin
                m_pend = m_pend | tr;
            end
        end
        #1;
        if (sched.size() > 0) exp_vec = {exp_ready, sched[0].d, sched[0].frame, 1'b1};
        else                  exp_vec = {exp_ready, 2'b00, 1'b0, 1'b0};
        obs_vec = {obs_ready, d_o, frame_o, busy_o};
        if (!rst) begin
            if (frame_o) begin
                rx_idx = 0;
                rx_cur = '0;
            end
            if (rx_idx < 4) begin
                rx_cur[rx_idx]   = d_o[0];
                rx_cur[4+rx_idx] = d_o[1];
                rx_idx++;
                if (rx_idx == 4) rx_words.push_back(rx_cur);
            end
        end
    endtask

    function automatic bit same_words();
        if (rx_words.size() != exp_words.size()) return 1'b0;
        foreach (rx_words[i]) if (rx_words[i] !== exp_words[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int count_word(input logic [7:0] w);
        int n = 0;
        foreach (rx_words[i]) if (rx_words[i] === w) n++;
        return n;
    endfunction

    task automatic clear_queues();
        exp_words.delete();
        rx_words.delete();
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b1, 8'hFF, 1'b1);
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({d_o, frame_o, busy_o} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_out got=%b exp=0000", {d_o, frame_o, busy_o});
        end
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b0, 1'b0, 8'($urandom), 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL idle cyc=%0d got=%b exp=%b (ready,d,frame,busy)", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[$];
        int idx = 0;
        bit v;
        clear_queues();
        words = '{8'hA5, 8'h3C, 8'hF0};
        for (int i = 0; i < 3; i++) words.push_back(8'($urandom));
        for (int c = 0; c < 80 && (idx < words.size() || sched.size() > 0); c++) begin
            v = (idx < words.size());
            drive_cycle(1'b0, v, v ? words[idx] : 8'h00, 1'b0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL b2b cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
            end
            if (v && exp_ready) idx++;
        end
        checks++;
        if (!same_words() || rx_words.size() != words.size() ||
            rx_words[0] !== 8'hA5 || rx_words[1] !== 8'h3C || rx_words[2] !== 8'hF0) begin
            failures++;
            $display("[TB] FAIL b2b_words got_n=%0d exp_n=%0d", rx_words.size(), words.size());
        end
    endtask

    task automatic test_train_idle();
        bit sent = 1'b0;
        bit v;
        clear_queues();
        for (int c = 0; c < 80 && (!sent || sched.size() > 0); c++) begin
            v = !sent && c > 0;
            drive_cycle(1'b0, v, 8'h12, c == 0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL train_idle cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
            end
            if (v && exp_ready) sent = 1'b1;
        end
        checks++;
        if (!same_words() || rx_words.size() != TW + 1 || count_word(TRAIN_WORD) != TW ||
            rx_words[TW] !== 8'h12) begin
            failures++;
            $display("[TB] FAIL train_idle_words got_n=%0d exp_n=%0d", rx_words.size(), TW + 1);
        end
    endtask

    task automatic test_train_during_send();
        clear_queues();
        drive_cycle(1'b0, 1'b1, 8'h55, 1'b0);
        for (int c = 0; c < 120 && (c < 3 || sched.size() > 0); c++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, c == 1 || c == 14);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL train_send cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
            end
        end
        checks++;
        if (!same_words() || rx_words.size() == 0 || rx_words[0] !== 8'h55 ||
            count_word(TRAIN_WORD) != 2 * TW) begin
            failures++;
            $display("[TB] FAIL train_send_words got_train=%0d exp_train=%0d", count_word(TRAIN_WORD), 2 * TW);
        end
    endtask

    task automatic test_reset_mid_word();
        clear_queues();
        drive_cycle(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int c = 0; c < 2; c++) drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({d_o, frame_o, busy_o} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_mid_out got=%b exp=0000", {d_o, frame_o, busy_o});
        end
        for (int c = 0; c < 12; c++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
            checks++;
            if (obs_vec !== exp_vec || (c == 0 && obs_ready !== 1'b1)) begin
                failures++;
                $display("[TB] FAIL reset_mid cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
            end
        end
        checks++;
        if (rx_words.size() != 0) begin
            failures++;
            $display("[TB] FAIL reset_drop got_n=%0d exp_n=0", rx_words.size());
        end
    endtask

    task automatic test_train_and_valid();
        logic [7:0] w;
        bit sent = 1'b0;
        w = 8'($urandom);
        if (w == TRAIN_WORD) w = 8'h5A;
        clear_queues();
        for (int c = 0; c < 80 && (!sent || sched.size() > 0); c++) begin
            drive_cycle(1'b0, !sent, w, c == 0);
            checks++;
            if (obs_vec !== exp_vec || (c == 0 && obs_ready !== 1'b0)) begin
                failures++;
                $display("[TB] FAIL train_valid cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
            end
            if (!sent && exp_ready) sent = 1'b1;
        end
        checks++;
        if (!same_words() || rx_words.size() != TW + 1 || count_word(w) != 1 || rx_words[TW] !== w) begin
            failures++;
            $display("[TB] FAIL train_valid_words got_n=%0d exp_n=%0d", rx_words.size(), TW + 1);
        end
    endtask

    task automatic test_random();
        clear_queues();
        for (int c = 0; c < 400; c++) begin
            drive_cycle($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                        8'($urandom), $urandom_range(0, 39) == 0);
            checks++;
            if (obs_vec !== exp_vec) begin
                failures++;
                $display("[TB] FAIL random cyc=%0d got=%b exp=%b", c, obs_vec, exp_vec);
            end
        end
        for (int c = 0; c < 100 && sched.size() > 0; c++) drive_cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (!same_words() || sched.size() != 0) begin
            failures++;
            $display("[TB] FAIL random_words got_n=%0d exp_n=%0d", rx_words.size(), exp_words.size());
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_back_to_back();
        test_train_idle();
        test_train_during_send();
        test_reset_mid_word();
        test_train_and_valid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
